// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings and helpers for the data-memory responder.
//   - FSM state encoding (IDLE / WAIT / RESP)
//   - data and address widths
//   - lane_we(): byte-lane write enables for a word or byte store
package dmem_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Little-endian lanes: bit 0 enables [7:0], bit 1 enables [15:8].
  function automatic logic [1:0] lane_we(input logic is_byte, input logic addr0);
    if (!is_byte) begin
      return 2'b11;
    end
    return addr0 ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word-organised storage, synchronous write, combinational read.
// Ports:
//   clk    in   clock
//   we     in   2-bit byte-lane write enable ([0] -> bits 7:0, [1] -> bits 15:8)
//   idx    in   word index (shared by read and write)
//   wdata  in   write data, already placed in the enabled lane(s)
//   rdata  out  word at idx
// Contents are never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic              clk,
  input  logic [1:0]        we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we[0]) mem_q[idx][7:0]  <= wdata[7:0];
    if (we[1]) mem_q[idx][15:8] <= wdata[15:8];
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the CPU data-memory port.
// Accepts one load/store at a time over a valid/ready request channel,
// inserts WAIT_CYCLES wait states, commits the access atomically and holds
// the response on a valid/ready response channel until it is taken.
// Ports:
//   CLK, RESET (async, active-low)
//   req_valid/req_ready, req_we (1=store), req_byte (1=byte), req_addr (byte
//   address), req_wdata (byte stores use [7:0])
//   rsp_valid/rsp_ready, rsp_rdata (0 for stores/errors), rsp_err
//   err_count (only when DMEM_ERRCNT_EN is defined): saturating count of
//   error responses handed over.
// Optional feature macro: DMEM_ERRCNT_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
`ifdef DMEM_ERRCNT_EN
  output logic              rsp_err,
  output logic [15:0]       err_count
`else
  output logic              rsp_err
`endif
);

  localparam int          IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [15:0] DEPTH_L = 16'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYCLES);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d, byte_q, byte_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              accept, commit;
  logic              cur_we, cur_byte;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [14:0]       acc_idx;
  logic              acc_err;
  logic [1:0]        arr_we;
  logic [DATA_W-1:0] arr_wdata, arr_rdata, load_data;

  // RESET gates req_ready directly so it reads 0 for the whole reset window.
  assign req_ready = RESET && (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  // With zero wait states the access commits on the accept edge, so the
  // live request fields are used while IDLE; otherwise the latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      cur_we    = req_we;
      cur_byte  = req_byte;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end else begin
      cur_we    = we_q;
      cur_byte  = byte_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  assign acc_idx   = cur_addr[15:1];
  assign acc_err   = (!cur_byte && cur_addr[0]) || ({1'b0, acc_idx} >= DEPTH_L);
  assign arr_we    = (commit && cur_we && !acc_err) ? lane_we(cur_byte, cur_addr[0]) : 2'b00;
  // A byte store may land in either lane, so replicate the low byte.
  assign arr_wdata = cur_byte ? {cur_wdata[7:0], cur_wdata[7:0]} : cur_wdata;
  assign load_data = cur_byte ? {8'h00, (cur_addr[0] ? arr_rdata[15:8] : arr_rdata[7:0])}
                              : arr_rdata;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (CLK),
    .we    (arr_we),
    .idx   (acc_idx[IDX_W-1:0]),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    byte_d      = byte_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    commit      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          byte_d  = req_byte;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = WAIT_L;
          if (WAIT_CYCLES == 0) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          commit  = 1'b1;
          cnt_d   = 4'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = acc_err;
      rsp_rdata_d = (acc_err || cur_we) ? '0 : load_data;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Latched request fields carry no reset; they are only read after an accept.
  always_ff @(posedge CLK) begin
    we_q    <= we_d;
    byte_q  <= byte_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef DMEM_ERRCNT_EN
  logic [15:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (rsp_valid_q && rsp_ready && rsp_err_q && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) err_count_q <= 16'd0;
    else        err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one instance with WAIT_CYCLES=2
// and one with WAIT_CYCLES=0. Expected responses come from a reference
// memory model and are queued at request acceptance, then compared when
// the response handshake happens.
module tb_dmem_responder;

  localparam int CLK_P = 10;
  localparam int DEPTH = 256;
  localparam int WAITC = 2;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #(CLK_P/2) clk = ~clk;

  // Instance A (WAIT_CYCLES=2)
  logic        req_valid, req_ready, req_we, req_byte;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_rdata;
  // Instance B (WAIT_CYCLES=0)
  logic        w0_req_valid, w0_req_ready, w0_req_we, w0_req_byte;
  logic [15:0] w0_req_addr, w0_req_wdata;
  logic        w0_rsp_valid, w0_rsp_ready, w0_rsp_err;
  logic [15:0] w0_rsp_rdata;
`ifdef DMEM_ERRCNT_EN
  logic [15:0] err_count, w0_err_count;
`endif

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) u_dut (
    .CLK       (clk),
    .RESET     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_byte  (req_byte),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
`ifdef DMEM_ERRCNT_EN
    .rsp_err   (rsp_err),
    .err_count (err_count)
`else
    .rsp_err   (rsp_err)
`endif
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
    .CLK       (clk),
    .RESET     (rst_n),
    .req_valid (w0_req_valid),
    .req_ready (w0_req_ready),
    .req_we    (w0_req_we),
    .req_byte  (w0_req_byte),
    .req_addr  (w0_req_addr),
    .req_wdata (w0_req_wdata),
    .rsp_valid (w0_rsp_valid),
    .rsp_ready (w0_rsp_ready),
    .rsp_rdata (w0_rsp_rdata),
`ifdef DMEM_ERRCNT_EN
    .rsp_err   (w0_rsp_err),
    .err_count (w0_err_count)
`else
    .rsp_err   (w0_rsp_err)
`endif
  );

  int   n_chk = 0;
  int   n_err = 0;
  int   exp_errs = 0;
  exp_t exp_q[$];
  exp_t w0_exp_q[$];
  logic [15:0] mdl [2][DEPTH];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model of one access against memory image `inst`.
  function automatic exp_t model(input int inst, input logic we, input logic byt,
                                 input logic [15:0] addr, input logic [15:0] wdata);
    exp_t        e;
    logic [14:0] idx;
    idx     = addr[15:1];
    e.err   = (!byt && addr[0]) || (idx >= 15'(DEPTH));
    e.rdata = 16'h0000;
    if (!e.err) begin
      if (we) begin
        if (!byt)        mdl[inst][idx]       = wdata;
        else if (addr[0]) mdl[inst][idx][15:8] = wdata[7:0];
        else             mdl[inst][idx][7:0]  = wdata[7:0];
      end else if (!byt) begin
        e.rdata = mdl[inst][idx];
      end else begin
        e.rdata = addr[0] ? {8'h00, mdl[inst][idx][15:8]} : {8'h00, mdl[inst][idx][7:0]};
      end
    end
    return e;
  endfunction

  // Response monitors: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", rsp_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err, e.err);
        if (e.err) exp_errs++;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && w0_rsp_valid && w0_rsp_ready) begin
      if (w0_exp_q.size() == 0) begin
        chk("w0_rsp_unexpected", w0_rsp_valid, 1'b0);
      end else begin
        e = w0_exp_q.pop_front();
        chk("w0_rsp_rdata", w0_rsp_rdata, e.rdata);
        chk("w0_rsp_err", w0_rsp_err, e.err);
      end
    end
  end

  // Issue one request to instance A and return once rsp_valid is seen.
  // The accept edge is the first of WAIT_CYCLES+1 edges, so WAITC further
  // edges pass before rsp_valid is observed.
  task automatic do_req(input logic we, input logic byt,
                        input logic [15:0] addr, input logic [15:0] wdata);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_byte = byt; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", req_ready, 1'b1);
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(0, we, byt, addr, wdata));
    @(posedge clk);
    #1;
    // Scramble the request fields: the DUT must use its latched copy.
    req_valid = 1'b0; req_we = ~we; req_byte = ~byt;
    req_addr  = 16'($urandom); req_wdata = 16'($urandom);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, WAITC);
  endtask

  task automatic wait_rsp_done();
    int n;
    n = 0;
    while (rsp_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rsp_drain", rsp_valid, 1'b0);
  endtask

  initial begin
    #(CLK_P * 20000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ro;
    logic        re;
    int          n;
    time         t_acc, t_last;
    logic        w_we   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic        w_byte [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] w_addr [4] = '{16'h0004, 16'h0004, 16'h0005, 16'h0004};
    logic [15:0] w_data [4] = '{16'hA55A, 16'h0000, 16'h0000, 16'h0000};

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    w0_req_valid = 1'b0; w0_req_we = 1'b0; w0_req_byte = 1'b0;
    w0_req_addr = '0; w0_req_wdata = '0; w0_rsp_ready = 1'b1;

    #3;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 16'h0000);
    chk("rst_rsp_err", rsp_err, 1'b0);
`ifdef DMEM_ERRCNT_EN
    chk("rst_err_count", err_count, 16'h0000);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Word store / load
    do_req(1'b1, 1'b0, 16'h0000, 16'h1111);
    do_req(1'b1, 1'b0, 16'h0010, 16'hBEEF);
    do_req(1'b0, 1'b0, 16'h0010, 16'h0000);
    // Byte store to upper lane, byte loads of both lanes, word load
    do_req(1'b1, 1'b1, 16'h0011, 16'h0042);
    do_req(1'b0, 1'b1, 16'h0011, 16'h0000);
    do_req(1'b0, 1'b1, 16'h0010, 16'h0000);
    do_req(1'b0, 1'b0, 16'h0010, 16'h0000);
    // Misaligned word load and out-of-range word store
    do_req(1'b0, 1'b0, 16'h0003, 16'h0000);
    do_req(1'b1, 1'b0, 16'h0200, 16'h7777);
    do_req(1'b0, 1'b0, 16'h0010, 16'h0000);
    do_req(1'b0, 1'b0, 16'h0000, 16'h0000);
    do_req(1'b0, 1'b1, 16'h0001, 16'h0000);
    wait_rsp_done();
`ifdef DMEM_ERRCNT_EN
    chk("err_count", err_count, 32'(exp_errs));
`endif

    // Backpressure: response held for 5 cycles, a request pulse is ignored
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    do_req(1'b0, 1'b0, 16'h0010, 16'h0000);
    ro = rsp_rdata;
    re = rsp_err;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_rsp_rdata", rsp_rdata, ro);
      chk("bp_rsp_err", rsp_err, re);
      chk("bp_req_ready", req_ready, 1'b0);
      if (i == 1) begin
        req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0;
        req_addr = 16'h0010; req_wdata = 16'hDEAD;
      end else if (i == 2) begin
        req_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_rsp_done();
    do_req(1'b0, 1'b0, 16'h0010, 16'h0000);

    // Reset in the middle of a store's wait states
    do_req(1'b1, 1'b0, 16'h0020, 16'h5555);
    wait_rsp_done();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_addr = 16'h0020; req_wdata = 16'h1234;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_accept", req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    exp_errs = 0;
    #1;
    chk("mid_rst_req_ready", req_ready, 1'b0);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_rsp_rdata", rsp_rdata, 16'h0000);
    chk("mid_rst_rsp_err", rsp_err, 1'b0);
`ifdef DMEM_ERRCNT_EN
    chk("mid_rst_err_count", err_count, 16'h0000);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 1'b0, 16'h0020, 16'h0000);
    wait_rsp_done();

    // Zero-wait instance: requests held back to back
    t_last = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      w0_req_valid = 1'b1; w0_req_we = w_we[k]; w0_req_byte = w_byte[k];
      w0_req_addr = w_addr[k]; w0_req_wdata = w_data[k];
      n = 0;
      while (!w0_req_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!w0_req_ready) begin
        chk("w0_accept_timeout", w0_req_ready, 1'b1);
        break;
      end
      w0_exp_q.push_back(model(1, w_we[k], w_byte[k], w_addr[k], w_data[k]));
      @(posedge clk);
      t_acc = $time;
      #1;
      chk("w0_latency", w0_rsp_valid, 1'b1);
      if (k > 0) chk("w0_accept_spacing", 32'((t_acc - t_last) / CLK_P), 32'd2);
      t_last = t_acc;
    end
    @(negedge clk);
    w0_req_valid = 1'b0;
    repeat (4) @(negedge clk);

    chk("queue_empty", exp_q.size(), 0);
    chk("w0_queue_empty", w0_exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
